// File: rtl/sensor_msg_fmt.sv
// Samples temperature and humidity, converts each to three ASCII digits by repeated
// subtraction, then streams a 17-byte text line over a valid/ready byte handshake.
module sensor_msg_fmt #(
    parameter int unsigned BLANK_LEADING = 1,
    parameter int unsigned CLAMP_MAX     = 999,
    parameter logic [7:0]  TEMP_UNIT     = 8'h43
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] temp_val,
    input  logic [15:0] hum_val,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        CONV_T,
        CONV_H,
        SEND
    } state_t;

    localparam logic [15:0] LP_CLAMP = 16'(CLAMP_MAX);
    localparam logic [4:0]  LP_LAST  = 5'd16;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_wt;
    logic [9:0]  r_wh;
    logic [3:0]  r_th;
    logic [3:0]  r_tt;
    logic [3:0]  r_tu;
    logic [3:0]  r_hh;
    logic [3:0]  r_ht;
    logic [3:0]  r_hu;
    logic [4:0]  r_idx;
    logic        r_done;

    logic [9:0]  w_t_clamp;
    logic [9:0]  w_h_clamp;
    logic        w_xfer;
    logic        w_last;
    logic        w_conv_t_end;
    logic        w_conv_h_end;
    logic        w_t_hblank;
    logic        w_t_tblank;
    logic        w_h_hblank;
    logic        w_h_tblank;
    logic [7:0]  w_byte;

    function automatic logic [7:0] f_digit(input logic [3:0] d, input logic blank);
        return blank ? 8'h20 : {4'h3, d};
    endfunction

    assign w_t_clamp    = (temp_val > LP_CLAMP) ? LP_CLAMP[9:0] : temp_val[9:0];
    assign w_h_clamp    = (hum_val  > LP_CLAMP) ? LP_CLAMP[9:0] : hum_val[9:0];
    assign w_xfer       = (r_state == SEND) && tx_data_ready;
    assign w_last       = w_xfer && (r_idx == LP_LAST);
    assign w_conv_t_end = (r_wt < 10'd10);
    assign w_conv_h_end = (r_wh < 10'd10);

    // Tens is only blanked when hundreds is blanked too, so "105" keeps its zero.
    assign w_t_hblank   = (BLANK_LEADING != 0) && (r_th == 4'd0);
    assign w_t_tblank   = w_t_hblank && (r_tt == 4'd0);
    assign w_h_hblank   = (BLANK_LEADING != 0) && (r_hh == 4'd0);
    assign w_h_tblank   = w_h_hblank && (r_ht == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        tx_data_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = CONV_T;
                end
            end
            CONV_T: begin
                if (w_conv_t_end) begin
                    w_state_next = CONV_H;
                end
            end
            CONV_H: begin
                if (w_conv_h_end) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                tx_data_valid = 1'b1;
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wt   <= '0;
            r_wh   <= '0;
            r_th   <= '0;
            r_tt   <= '0;
            r_tu   <= '0;
            r_hh   <= '0;
            r_ht   <= '0;
            r_hu   <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wt  <= w_t_clamp;
                        r_wh  <= w_h_clamp;
                        r_th  <= '0;
                        r_tt  <= '0;
                        r_tu  <= '0;
                        r_hh  <= '0;
                        r_ht  <= '0;
                        r_hu  <= '0;
                        r_idx <= '0;
                    end
                end
                CONV_T: begin
                    if (r_wt >= 10'd100) begin
                        r_wt <= r_wt - 10'd100;
                        r_th <= r_th + 4'd1;
                    end else if (r_wt >= 10'd10) begin
                        r_wt <= r_wt - 10'd10;
                        r_tt <= r_tt + 4'd1;
                    end else begin
                        r_tu <= r_wt[3:0];
                    end
                end
                CONV_H: begin
                    if (r_wh >= 10'd100) begin
                        r_wh <= r_wh - 10'd100;
                        r_hh <= r_hh + 4'd1;
                    end else if (r_wh >= 10'd10) begin
                        r_wh <= r_wh - 10'd10;
                        r_ht <= r_ht + 4'd1;
                    end else begin
                        r_hu  <= r_wh[3:0];
                        r_idx <= '0;
                    end
                end
                SEND: begin
                    if (w_last) begin
                        r_idx <= '0;
                    end else if (w_xfer) begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            5'd0:    w_byte = 8'h54;
            5'd1:    w_byte = 8'h3D;
            5'd2:    w_byte = f_digit(r_th, w_t_hblank);
            5'd3:    w_byte = f_digit(r_tt, w_t_tblank);
            5'd4:    w_byte = f_digit(r_tu, 1'b0);
            5'd5:    w_byte = 8'h20;
            5'd6:    w_byte = TEMP_UNIT;
            5'd7:    w_byte = 8'h20;
            5'd8:    w_byte = 8'h48;
            5'd9:    w_byte = 8'h3D;
            5'd10:   w_byte = f_digit(r_hh, w_h_hblank);
            5'd11:   w_byte = f_digit(r_ht, w_h_tblank);
            5'd12:   w_byte = f_digit(r_hu, 1'b0);
            5'd13:   w_byte = 8'h20;
            5'd14:   w_byte = 8'h25;
            5'd15:   w_byte = 8'h0D;
            5'd16:   w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    assign tx_data = tx_data_valid ? w_byte : 8'h00;
    assign done    = r_done;

endmodule

// File: tb/tb_sensor_msg_fmt.sv
// Directed bench for sensor_msg_fmt: table-driven messages plus backpressure,
// mid-message restart, start-on-done and reset-abort sequences.
module tb_sensor_msg_fmt;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] temp_val;
    logic [15:0] hum_val;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        busy;
    logic        done;

    logic        start2;
    logic [15:0] temp2;
    logic [15:0] hum2;
    logic [7:0]  tx_data2;
    logic        valid2;
    logic        ready2;
    logic        busy2;
    logic        done2;

    int n_pass;
    int n_total;

    sensor_msg_fmt dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .temp_val      (temp_val),
        .hum_val       (hum_val),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .done          (done)
    );

    sensor_msg_fmt #(.BLANK_LEADING(0)) dut_nb (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .temp_val      (temp2),
        .hum_val       (hum2),
        .tx_data       (tx_data2),
        .tx_data_valid (valid2),
        .tx_data_ready (ready2),
        .busy          (busy2),
        .done          (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic [15:0] h;
        logic [23:0] ft;
        logic [23:0] fh;
    } vec_t;

    function automatic logic [135:0] mk_msg(input logic [23:0] ft, input logic [23:0] fh);
        return {8'h54, 8'h3D, ft, 8'h20, 8'h43, 8'h20, 8'h48, 8'h3D, fh,
                8'h20, 8'h25, 8'h0D, 8'h0A};
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_msg(input logic [15:0] t, input logic [15:0] h);
        temp_val = t;
        hum_val  = h;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: ready always 1; 1: ~30% random; 2: random plus 50-cycle stall on byte 7
    task automatic capture(input int mode, input bit mid_restart, input bit start_on_done,
                           output logic [135:0] msg, output int ndone, output int lat,
                           output int viol, output int hold, output bit idle_after);
        int   n;
        int   post;
        bit   pend;
        bit   mr_done;
        bit   rdy;
        logic [7:0] pdata;
        n = 0; post = 0; pend = 0; mr_done = 0; pdata = '0;
        msg = '0; ndone = 0; lat = -1; viol = 0; hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (lat < 0 && tx_data_valid) lat = cyc;
            if (done) begin
                ndone++;
                if (start_on_done) begin
                    start    = 1'b1;
                    temp_val = 16'd77;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    break;
                end
            end
            if (pend && (!tx_data_valid || tx_data != pdata)) viol++;
            if (n > 0 && n < 17 && !tx_data_valid) viol++;
            if (n == 17) begin
                post++;
                if (tx_data_valid) viol++;
                if (post > 4) break;
            end
            case (mode)
                0:       rdy = 1'b1;
                default: rdy = ($urandom_range(0, 9) < 3);
            endcase
            if (mode == 2 && n == 7 && tx_data_valid && hold < 50) begin
                rdy = 1'b0;
                hold++;
                if (tx_data != 8'h20) viol++;
            end
            if (mid_restart) begin
                start = (n == 5) && !mr_done;
                if (start) begin
                    temp_val = 16'd77;
                    mr_done  = 1'b1;
                end
            end
            tx_data_ready = rdy;
            pend  = tx_data_valid && !rdy;
            pdata = tx_data;
            if (tx_data_valid && rdy && n < 17) begin
                msg = {msg[127:0], tx_data};
                n++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        idle_after = !busy && !tx_data_valid;
    endtask

    vec_t          vecs[5];
    logic [135:0]  msg;
    logic [135:0]  exp25;
    int            ndone;
    int            lat;
    int            viol;
    int            hold;
    bit            idle_after;

    initial begin
        vecs[0] = '{t: 16'd25,   h: 16'd60,    ft: 24'h203235, fh: 24'h203630};
        vecs[1] = '{t: 16'd0,    h: 16'd100,   ft: 24'h202030, fh: 24'h313030};
        vecs[2] = '{t: 16'd1234, h: 16'd65535, ft: 24'h393939, fh: 24'h393939};
        vecs[3] = '{t: 16'd999,  h: 16'd7,     ft: 24'h393939, fh: 24'h202037};
        vecs[4] = '{t: 16'd105,  h: 16'd10,    ft: 24'h313035, fh: 24'h203130};

        n_pass = 0; n_total = 0;
        rst = 1'b1; start = 1'b0; temp_val = '0; hum_val = '0; tx_data_ready = 1'b0;
        start2 = 1'b0; temp2 = '0; hum2 = '0; ready2 = 1'b1;
        exp25 = {8'h54, 8'h3D, 8'h20, 8'h32, 8'h35, 8'h20, 8'h43, 8'h20, 8'h48,
                 8'h3D, 8'h20, 8'h36, 8'h30, 8'h20, 8'h25, 8'h0D, 8'h0A};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 136'({tx_data, tx_data_valid, busy, done}), 136'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            start_msg(vecs[i].t, vecs[i].h);
            capture(0, 1'b0, 1'b0, msg, ndone, lat, viol, hold, idle_after);
            chk($sformatf("msg_vec%0d", i), msg, mk_msg(vecs[i].ft, vecs[i].fh));
            chk($sformatf("done_vec%0d", i), 136'(ndone), 136'(1));
            chk($sformatf("lat_vec%0d", i), 136'(lat >= 0 && lat <= 40), 136'(1));
            chk($sformatf("idle_vec%0d", i), 136'({idle_after, 8'(viol)}), 136'(9'h100));
        end

        // backpressure: random ready plus a long stall on byte 7
        start_msg(16'd25, 16'd60);
        capture(2, 1'b0, 1'b0, msg, ndone, lat, viol, hold, idle_after);
        chk("bp_msg", msg, exp25);
        chk("bp_done", 136'(ndone), 136'(1));
        chk("bp_stable", 136'(viol), 136'(0));
        chk("bp_hold", 136'(hold), 136'(50));

        // restart mid-message is ignored, later temp change has no effect
        start_msg(16'd25, 16'd60);
        capture(1, 1'b1, 1'b0, msg, ndone, lat, viol, hold, idle_after);
        chk("restart_msg", msg, exp25);
        chk("restart_done", 136'(ndone), 136'(1));
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            if (tx_data_valid || busy) viol++;
            @(posedge clk);
            #1;
        end
        chk("restart_no_second", 136'({idle_after, 8'(viol)}), 136'(9'h100));

        // start asserted in the done cycle
        start_msg(16'd25, 16'd60);
        capture(0, 1'b0, 1'b1, msg, ndone, lat, viol, hold, idle_after);
        chk("sod_first_msg", msg, exp25);
        capture(0, 1'b0, 1'b0, msg, ndone, lat, viol, hold, idle_after);
        chk("sod_second_msg", msg, mk_msg(24'h203737, 24'h203630));
        chk("sod_second_done", 136'(ndone), 136'(1));

        // reset while byte 5 is pending
        start_msg(16'd25, 16'd60);
        tx_data_ready = 1'b1;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 200 && n < 5; c++) begin
                if (tx_data_valid) n++;
                @(posedge clk);
                #1;
            end
        end
        tx_data_ready = 1'b0;
        chk("rst_pending_byte", 136'({tx_data_valid, tx_data}), 136'(9'h120));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_abort", 136'({tx_data, tx_data_valid, busy, done}), 136'(0));
        start_msg(16'd25, 16'd60);
        capture(0, 1'b0, 1'b0, msg, ndone, lat, viol, hold, idle_after);
        chk("rst_new_msg", msg, exp25);

        // no leading-zero blanking
        temp2 = 16'd5; hum2 = 16'd42; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        msg = '0;
        begin
            int n2;
            n2 = 0;
            for (int c = 0; c < 200 && n2 < 17; c++) begin
                if (valid2) begin
                    msg = {msg[127:0], tx_data2};
                    n2++;
                end
                @(posedge clk);
                #1;
            end
        end
        chk("noblank_msg", msg, mk_msg(24'h303035, 24'h303432));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
